// File: rtl/sdq_pkg.sv
// sdq_pkg: sizes, types and pointer-wrap helper shared by the store-data-queue controller.
package sdq_pkg;
  localparam int SDQ_DEPTH  = 17;
  localparam int SDQ_WIDTH  = 64;
  localparam int SDQ_ADDR_W = 5;
  typedef logic [SDQ_ADDR_W-1:0] sdq_ptr_t;
  typedef logic [SDQ_WIDTH-1:0]  sdq_data_t;
  function automatic sdq_ptr_t sdq_ptr_inc(input sdq_ptr_t p);
    return (p == sdq_ptr_t'(SDQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
endpackage

// File: rtl/sdq_if.sv
// sdq_if: enqueue/dequeue handshakes, flush, occupancy and sdq_17x64 macro port signals.
interface sdq_if;
  import sdq_pkg::*;
  logic      flush;
  logic      enq_valid;
  logic      enq_ready;
  sdq_data_t enq_data;
  logic      deq_valid;
  logic      deq_ready;
  sdq_data_t deq_data;
  sdq_ptr_t  count;
  sdq_ptr_t  mem_w_addr;
  logic      mem_w_en;
  sdq_data_t mem_w_data;
  sdq_ptr_t  mem_r_addr;
  logic      mem_r_en;
  sdq_data_t mem_r_data;
  modport master (
    output flush, enq_valid, enq_data, deq_ready, mem_r_data,
    input  enq_ready, deq_valid, deq_data, count, mem_w_addr, mem_w_en, mem_w_data, mem_r_addr, mem_r_en
  );
  modport slave (
    input  flush, enq_valid, enq_data, deq_ready, mem_r_data,
    output enq_ready, deq_valid, deq_data, count, mem_w_addr, mem_w_en, mem_w_data, mem_r_addr, mem_r_en
  );
endinterface

// File: rtl/sdq_ptr.sv
// sdq_ptr: circular pointer that wraps at SDQ_DEPTH, with synchronous clear and increment enable.
module sdq_ptr
  import sdq_pkg::*;
(
  input  logic     clock,
  input  logic     i_clr,
  input  logic     i_inc,
  output sdq_ptr_t o_ptr
);
  sdq_ptr_t r_ptr;
  always_ff @(posedge clock) begin
    if (i_clr) r_ptr <= '0;
    else if (i_inc) r_ptr <= sdq_ptr_inc(r_ptr);
  end
  assign o_ptr = r_ptr;
endmodule

// File: rtl/sdq_ctrl.sv
// sdq_ctrl: in-order FIFO control around the sdq_17x64 macro with a registered dequeue stage.
// Define SDQ_BYPASS_EN to let enqueues into an empty queue skip memory (1-cycle latency).
module sdq_ctrl
  import sdq_pkg::*;
(
  input logic  clock,
  input logic  reset,
  sdq_if.slave bus
);
  logic      w_clr, w_enq_fire, w_slot, w_fetch, w_bypass, w_wr;
  sdq_ptr_t  w_head, w_tail, r_count;
  logic      r_deq_valid;
  sdq_data_t r_deq_data;
  always_comb begin
    w_clr      = reset | bus.flush;
    w_enq_fire = bus.enq_valid & (r_count != sdq_ptr_t'(SDQ_DEPTH));
    w_slot     = !r_deq_valid | bus.deq_ready;
    w_fetch    = (r_count != '0) & w_slot;
`ifdef SDQ_BYPASS_EN
    w_bypass   = (r_count == '0) & w_slot & w_enq_fire;
`else
    w_bypass   = 1'b0;
`endif
    // a clearing edge must not leave a stale write behind at the old tail
    w_wr       = w_enq_fire & !w_bypass & !w_clr;
  end
  sdq_ptr u_head (.clock(clock), .i_clr(w_clr), .i_inc(w_fetch), .o_ptr(w_head));
  sdq_ptr u_tail (.clock(clock), .i_clr(w_clr), .i_inc(w_wr),    .o_ptr(w_tail));
  always_ff @(posedge clock) begin
    if (w_clr) begin
      r_count     <= '0;
      r_deq_valid <= 1'b0;
      r_deq_data  <= '0;
    end else begin
      r_count <= r_count + sdq_ptr_t'(w_wr) - sdq_ptr_t'(w_fetch);
      if (w_fetch) begin
        r_deq_valid <= 1'b1;
        r_deq_data  <= bus.mem_r_data;
      end else if (w_bypass) begin
        r_deq_valid <= 1'b1;
        r_deq_data  <= bus.enq_data;
      end else if (bus.deq_ready) begin
        r_deq_valid <= 1'b0;
      end
    end
  end
  assign bus.enq_ready  = (r_count != sdq_ptr_t'(SDQ_DEPTH));
  assign bus.deq_valid  = r_deq_valid;
  assign bus.deq_data   = r_deq_data;
  assign bus.count      = r_count;
  assign bus.mem_w_en   = w_wr;
  assign bus.mem_w_addr = w_tail;
  assign bus.mem_w_data = bus.enq_data;
  assign bus.mem_r_en   = w_fetch;
  assign bus.mem_r_addr = w_head;
endmodule

// File: tb/tb_sdq_ctrl.sv
// tb_sdq_ctrl: directed bench with a memory model and an in-order scoreboard for sdq_ctrl.
module tb_sdq_ctrl;
  import sdq_pkg::*;
`ifdef SDQ_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rnd = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [63:0] q [$];
  logic [63:0] mem [0:31];
  logic [4:0]  tail_m = '0;
  logic        held_v = 1'b0;
  logic [63:0] held_d = '0;
  sdq_if b ();
  sdq_ctrl dut (.clock(clk), .reset(rst), .bus(b.slave));
  always #5 clk = ~clk;
  always @(posedge clk) if (b.mem_w_en) mem[b.mem_w_addr] <= b.mem_w_data;
  assign b.mem_r_data = b.mem_r_en ? mem[b.mem_r_addr] : 'x;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst || b.flush) begin
      q.delete();
      tail_m = '0;
      held_v = 1'b0;
    end else begin
      if (b.mem_w_en) begin
        chk("w_addr", 64'(b.mem_w_addr), 64'(tail_m));
        tail_m = (tail_m == 5'd16) ? 5'd0 : tail_m + 5'd1;
      end
      if (held_v) begin
        chk("stall_valid", 64'(b.deq_valid), 64'(1));
        chk("stall_data", b.deq_data, held_d);
      end
      if (b.deq_valid && b.deq_ready) begin
        chk("deq_expected", 64'(q.size() != 0), 64'(1));
        if (q.size() != 0) chk("deq_data", b.deq_data, q.pop_front());
      end
      held_v = b.deq_valid && !b.deq_ready;
      held_d = b.deq_data;
      if (b.enq_valid && b.enq_ready) q.push_back(b.enq_data);
      chk("count_max", 64'(b.count <= 5'd17), 64'(1));
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic enq(input logic [63:0] v);
    logic acc = 1'b0;
    b.enq_valid = 1'b1;
    b.enq_data  = v;
    for (int n = 0; n < 100 && !acc; n++) begin
      if (rnd) b.deq_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = b.enq_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) chk("enq_accept", 64'(b.enq_ready), 64'(1));
    b.enq_valid = 1'b0;
  endtask
  task automatic drain();
    b.deq_ready = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (q.size() == 0 && !b.deq_valid) break;
    end
    @(posedge clk);
    #1;
    chk("drain_q", 64'(q.size()), 64'(0));
    chk("drain_valid", 64'(b.deq_valid), 64'(0));
    chk("drain_count", 64'(b.count), 64'(0));
  endtask
  initial begin
    b.flush = 1'b0;
    b.enq_valid = 1'b0;
    b.enq_data = '0;
    b.deq_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("rst_count", 64'(b.count), 64'(0));
    chk("rst_valid", 64'(b.deq_valid), 64'(0));
    chk("rst_data", b.deq_data, 64'(0));
    chk("rst_ready", 64'(b.enq_ready), 64'(1));
    // reset in the middle of traffic
    for (int i = 1; i <= 5; i++) enq(64'(i));
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("midrst_count", 64'(b.count), 64'(0));
    chk("midrst_valid", 64'(b.deq_valid), 64'(0));
    chk("midrst_ready", 64'(b.enq_ready), 64'(1));
    b.deq_ready = 1'b1;
    enq(64'hA5);
    for (int n = 0; n < 10 && !b.deq_valid; n++) @(negedge clk);
    chk("midrst_first", b.deq_data, 64'hA5);
    drain();
    // empty-queue latency
    b.enq_valid = 1'b1;
    b.enq_data  = 64'h1234;
    @(negedge clk);
    chk("lat_wen", 64'(b.mem_w_en), 64'(!BYP));
    cyc(1);
    b.enq_valid = 1'b0;
    chk("lat_c1_valid", 64'(b.deq_valid), 64'(BYP));
    cyc(1);
    chk("lat_c2_valid", 64'(b.deq_valid), 64'(!BYP));
    drain();
    // fill to 17 in memory plus the output register
    b.deq_ready = 1'b0;
    for (int i = 0; i < 18; i++) enq(64'(i));
    cyc(1);
    chk("full_count", 64'(b.count), 64'(17));
    chk("full_valid", 64'(b.deq_valid), 64'(1));
    chk("full_data", b.deq_data, 64'(0));
    chk("full_ready", 64'(b.enq_ready), 64'(0));
    b.enq_valid = 1'b1;
    b.enq_data  = 64'h99;
    repeat (3) begin
      @(negedge clk);
      chk("full_reject", 64'(b.enq_ready), 64'(0));
      chk("full_no_wr", 64'(b.mem_w_en), 64'(0));
    end
    cyc(1);
    b.enq_valid = 1'b0;
    drain();
    // streaming through the pointer wrap
    b.deq_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      cyc($urandom_range(0, 2));
      enq(64'(i));
    end
    drain();
    // random backpressure
    rnd = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) cyc(1);
      enq(64'h1000 + 64'(i));
    end
    rnd = 1'b0;
    drain();
    // flush with concurrent enqueue and dequeue
    b.deq_ready = 1'b0;
    for (int i = 0; i < 10; i++) enq(64'h200 + 64'(i));
    cyc(1);
    chk("pre_flush_count", 64'(b.count), 64'(9));
    b.flush = 1'b1;
    b.enq_valid = 1'b1;
    b.enq_data = 64'hF00;
    b.deq_ready = 1'b1;
    @(negedge clk);
    chk("flush_no_wr", 64'(b.mem_w_en), 64'(0));
    cyc(1);
    b.flush = 1'b0;
    b.enq_valid = 1'b0;
    chk("flush_count", 64'(b.count), 64'(0));
    chk("flush_valid", 64'(b.deq_valid), 64'(0));
    chk("flush_data", b.deq_data, 64'(0));
    chk("flush_ready", 64'(b.enq_ready), 64'(1));
    enq(64'h77);
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
